sprite_sat_writer: RTL and testbench

Sprite-attribute-table (SAT) writer for the Green Beret video subsystem. It copies a 48-entry sprite list from CPU work RAM into the off-screen bank of the double-buffered SAT in MRAM. Disabled sprites (Y=0) are compacted out, and unused slots are blanked. At the next vertical blank it flips the displayed bank, so the sprite renderer always scans a complete, consistent table.

---
 rtl/sprite_sat_writer.sv | 135 +++++++++++++
 tb/tb_sprite_sat_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_sat_writer.sv
// rtl/sprite_sat_writer.sv - copies the CPU sprite list into the hidden SAT bank, compacting disabled entries
// The displayed bank flips on the first VBLK rise seen after the copy completes.
module sprite_sat_writer #(
  parameter int SPRITES = 48
) (
  input  logic        CPUCL,
  input  logic        RESETn,
  input  logic        START,
  input  logic        VBLK,
  input  logic [15:0] SRCBASE,
  output logic [15:0] SRCAD,
  output logic        SRCRQ,
  input  logic        SRCACK,
  input  logic [7:0]  SRCDT,
  output logic [11:0] SATAD,
  output logic        SATWE,
  output logic [7:0]  SATWD,
  output logic        SPRB,
  output logic        BUSY,
  output logic [5:0]  LIVE
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RDY   = 3'd1;
  localparam logic [2:0] RDB   = 3'd2;
  localparam logic [2:0] NEXT  = 3'd3;
  localparam logic [2:0] FILL  = 3'd4;
  localparam logic [2:0] WFLIP = 3'd5;

  // Counters carry one extra bit so that SPRITES=64 is reachable.
  localparam logic [6:0] LAST = 7'(SPRITES);

  logic [2:0]  state;
  logic [15:0] base_q;
  logic [6:0]  n;
  logic [6:0]  m;
  logic [1:0]  k;
  logic        vblk_q;

  assign BUSY = (state != IDLE);

  always_ff @(posedge CPUCL or negedge RESETn) begin
    if (!RESETn) begin
      state  <= IDLE;
      base_q <= 16'h0000;
      n      <= 7'd0;
      m      <= 7'd0;
      k      <= 2'd0;
      vblk_q <= 1'b0;
      SRCAD  <= 16'h0000;
      SRCRQ  <= 1'b0;
      SATAD  <= 12'h000;
      SATWE  <= 1'b0;
      SATWD  <= 8'h00;
      SPRB   <= 1'b0;
      LIVE   <= 6'd0;
    end else begin
      vblk_q <= VBLK;
      SATWE  <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            base_q <= SRCBASE;
            n      <= 7'd0;
            m      <= 7'd0;
            state  <= RDY;
          end
        end
        RDY: begin
          if (!SRCRQ) begin
            SRCRQ <= 1'b1;
            SRCAD <= base_q + {8'b0, n[5:0], 2'b11};
          end else if (SRCACK) begin
            SRCRQ <= 1'b0;
            if (SRCDT == 8'h00) begin
              n     <= n + 7'd1;
              state <= NEXT;
            end else begin
              SATWE <= 1'b1;
              SATAD <= {3'b000, ~SPRB, m[5:0], 2'b11};
              SATWD <= SRCDT;
              k     <= 2'd2;
              state <= RDB;
            end
          end
        end
        RDB: begin
          if (!SRCRQ) begin
            SRCRQ <= 1'b1;
            SRCAD <= base_q + {8'b0, n[5:0], k};
          end else if (SRCACK) begin
            SRCRQ <= 1'b0;
            SATWE <= 1'b1;
            SATAD <= {3'b000, ~SPRB, m[5:0], k};
            SATWD <= SRCDT;
            if (k == 2'd0) begin
              m     <= m + 7'd1;
              n     <= n + 7'd1;
              state <= NEXT;
            end else begin
              k <= k - 2'd1;
            end
          end
        end
        NEXT: begin
          if (n == LAST) begin
            LIVE  <= m[5:0];
            state <= FILL;
          end else begin
            state <= RDY;
          end
        end
        FILL: begin
          // Blank the remaining slots by zeroing Y only.
          if (m == LAST) begin
            state <= WFLIP;
          end else begin
            SATWE <= 1'b1;
            SATAD <= {3'b000, ~SPRB, m[5:0], 2'b11};
            SATWD <= 8'h00;
            m     <= m + 7'd1;
          end
        end
        WFLIP: begin
          if (VBLK && !vblk_q) begin
            SPRB  <= ~SPRB;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_sat_writer.sv
// tb/tb_sprite_sat_writer.sv - self-checking bench for sprite_sat_writer
// Source memory responder and SAT write monitor run alongside a table of copy scenarios.
module tb_sprite_sat_writer;

  localparam int SPRITES = 48;

  logic        CPUCL = 1'b0;
  logic        RESETn;
  logic        START;
  logic        VBLK;
  logic [15:0] SRCBASE;
  logic [15:0] SRCAD;
  logic        SRCRQ;
  logic        SRCACK = 1'b0;
  logic [7:0]  SRCDT = 8'h00;
  logic [11:0] SATAD;
  logic        SATWE;
  logic [7:0]  SATWD;
  logic        SPRB;
  logic        BUSY;
  logic [5:0]  LIVE;

  always #5 CPUCL = ~CPUCL;

  sprite_sat_writer #(.SPRITES(SPRITES)) dut (
    .CPUCL(CPUCL), .RESETn(RESETn), .START(START), .VBLK(VBLK),
    .SRCBASE(SRCBASE), .SRCAD(SRCAD), .SRCRQ(SRCRQ), .SRCACK(SRCACK),
    .SRCDT(SRCDT), .SATAD(SATAD), .SATWE(SATWE), .SATWD(SATWD),
    .SPRB(SPRB), .BUSY(BUSY), .LIVE(LIVE)
  );

  typedef struct {
    logic [15:0] base;
    int          pat;
    int          max_wait;
    bit          spur;
    bit          hold;
    logic        bank;
    int          live;
    int          writes;
  } vec_t;

  vec_t tbl [5];

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] src_mem [0:65535];
  logic [7:0] sat     [0:4095];
  int         sat_gen [0:4095];

  int          scen = 0;
  logic        cur_bank = 1'b0;
  logic [15:0] cur_base = 16'h0000;
  int          max_wait = 0;
  bit          spurious = 1'b0;

  int wr_count = 0;
  int bad_bank = 0;
  int rq_unstable = 0;
  int out_of_win = 0;
  int hits_0003 = 0;

  bit          pending = 1'b0;
  int          wait_cnt = 0;
  logic [15:0] held_ad = 16'h0000;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  function automatic logic [7:0] entry_byte(input int pat, input int n, input int k);
    if (pat == 0) begin
      case (k)
        0: return 8'(n);
        1: return 8'h05;
        2: return 8'h80;
        default: return 8'(n + 1);
      endcase
    end else if (pat == 1) begin
      if (n == 3 || n == 10 || n == 47) return 8'(8'h10 * (k + 1) + n);
      return (k == 3) ? 8'h00 : 8'(8'h70 + n);
    end
    return (k == 3) ? 8'h00 : 8'(8'hA0 + n);
  endfunction

  task automatic fill_src(input logic [15:0] base, input int pat);
    for (int a = 0; a < 65536; a++) src_mem[a] = 8'hC3;
    for (int n = 0; n < SPRITES; n++)
      for (int k = 0; k < 4; k++)
        src_mem[16'(base + 4 * n + k)] = entry_byte(pat, n, k);
  endtask

  // Source responder: optional random wait states and stray ACKs while idle.
  always @(negedge CPUCL) begin
    if (SRCACK) begin
      SRCACK = 1'b0;
    end else if (RESETn === 1'b1 && SRCRQ === 1'b1) begin
      if (!pending) begin
        pending  = 1'b1;
        wait_cnt = (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
        held_ad  = SRCAD;
      end else if (SRCAD !== held_ad) begin
        rq_unstable++;
      end
      if (wait_cnt == 0) begin
        SRCACK  = 1'b1;
        SRCDT   = src_mem[SRCAD];
        pending = 1'b0;
        if (16'(SRCAD - cur_base) >= 16'(4 * SPRITES)) out_of_win++;
        if (SRCAD == 16'h0003) hits_0003++;
      end else begin
        wait_cnt--;
      end
    end else begin
      if (pending) rq_unstable++;
      pending = 1'b0;
      if (RESETn === 1'b1 && spurious && $urandom_range(0, 3) == 0) begin
        SRCACK = 1'b1;
        SRCDT  = 8'hEE;
      end
    end
  end

  always @(negedge CPUCL) begin
    if (RESETn === 1'b1 && SATWE === 1'b1) begin
      sat[SATAD]     = SATWD;
      sat_gen[SATAD] = scen;
      wr_count++;
      if (SATAD[8] !== cur_bank || SATAD[11:9] !== 3'b000) bad_bank++;
    end
  end

  task automatic run_row(input vec_t v, input int idx);
    int w0, b0, u0, o0, z0, c, errs, slot;
    bit done;
    logic [11:0] a;
    logic [15:0] exp_ad;
    logic nb;
    nb       = ~v.bank;
    exp_ad   = v.base + 16'd3;
    scen     = idx + 1;
    cur_bank = v.bank;
    cur_base = v.base;
    max_wait = v.max_wait;
    spurious = v.spur;
    fill_src(v.base, v.pat);
    w0 = wr_count; b0 = bad_bank; u0 = rq_unstable; o0 = out_of_win; z0 = hits_0003;
    if (v.hold) VBLK = 1'b1;
    SRCBASE = v.base;
    START   = 1'b1;
    @(negedge CPUCL);
    START   = 1'b0;
    SRCBASE = 16'h5555;
    check($sformatf("row%0d busy_after_start", idx), BUSY, 1);
    check($sformatf("row%0d srcrq_latency1", idx), SRCRQ, 0);
    @(negedge CPUCL);
    check($sformatf("row%0d srcrq_latency2", idx), SRCRQ, 1);
    check($sformatf("row%0d first_srcad", idx), SRCAD, exp_ad);
    c = 2;
    done = 1'b0;
    while (!done && c < 6000) begin
      @(negedge CPUCL);
      c++;
      if (c == 20) begin START = 1'b1; SRCBASE = 16'h1234; end
      if (c == 21) START = 1'b0;
      if (!v.hold && c == 30) VBLK = 1'b1;
      if (!v.hold && c == 33) VBLK = 1'b0;
      if (c > 40 && wr_count - w0 >= v.writes) done = 1'b1;
    end
    check($sformatf("row%0d copy_done", idx), done, 1);
    repeat (5) @(negedge CPUCL);
    check($sformatf("row%0d writes", idx), wr_count - w0, v.writes);
    check($sformatf("row%0d busy_in_wflip", idx), BUSY, 1);
    check($sformatf("row%0d no_early_flip", idx), SPRB, nb);
    check($sformatf("row%0d live", idx), LIVE, v.live);
    check($sformatf("row%0d bank_of_writes", idx), bad_bank - b0, 0);
    check($sformatf("row%0d rq_stable", idx), rq_unstable - u0, 0);
    check($sformatf("row%0d src_window", idx), out_of_win - o0, 0);
    if (v.base == 16'hFFF0) check($sformatf("row%0d wrap_read", idx), hits_0003 - z0, 1);
    errs = 0;
    slot = 0;
    for (int n = 0; n < SPRITES; n++) begin
      if (entry_byte(v.pat, n, 3) != 8'h00) begin
        for (int k = 0; k < 4; k++) begin
          a = {3'b000, v.bank, 6'(slot), 2'(k)};
          if (sat_gen[a] != scen || sat[a] !== entry_byte(v.pat, n, k)) errs++;
        end
        slot++;
      end
    end
    for (int s = slot; s < SPRITES; s++) begin
      for (int k = 0; k < 4; k++) begin
        a = {3'b000, v.bank, 6'(s), 2'(k)};
        if (k == 3) begin
          if (sat_gen[a] != scen || sat[a] !== 8'h00) errs++;
        end else if (sat_gen[a] == scen) begin
          errs++;
        end
      end
    end
    check($sformatf("row%0d sat_contents", idx), errs, 0);
    if (v.hold) begin
      VBLK = 1'b0;
      repeat (2) @(negedge CPUCL);
      check($sformatf("row%0d no_flip_held_vblk", idx), SPRB, nb);
    end
    VBLK = 1'b1;
    @(negedge CPUCL);
    check($sformatf("row%0d sprb_flipped", idx), SPRB, v.bank);
    check($sformatf("row%0d idle_after_flip", idx), BUSY, 0);
    VBLK = 1'b0;
    @(negedge CPUCL);
  endtask

  initial begin
    bit found;
    RESETn  = 1'b0;
    START   = 1'b0;
    VBLK    = 1'b0;
    SRCBASE = 16'h0000;

    tbl[0] = '{16'hD800, 0, 0, 1'b0, 1'b0, 1'b1, 48, 192};
    tbl[1] = '{16'hD800, 1, 0, 1'b0, 1'b0, 1'b0, 3, 57};
    tbl[2] = '{16'h2000, 2, 0, 1'b0, 1'b1, 1'b1, 0, 48};
    tbl[3] = '{16'hFFF0, 0, 5, 1'b1, 1'b0, 1'b0, 48, 192};
    tbl[4] = '{16'hFFF0, 1, 5, 1'b1, 1'b0, 1'b1, 3, 57};

    repeat (3) @(negedge CPUCL);
    check("reset SPRB", SPRB, 0);
    check("reset BUSY", BUSY, 0);
    check("reset LIVE", LIVE, 0);
    check("reset SRCRQ", SRCRQ, 0);
    check("reset SATWE", SATWE, 0);
    check("reset SRCAD", SRCAD, 0);
    check("reset SATAD", SATAD, 0);
    check("reset SATWD", SATWD, 0);
    RESETn = 1'b1;
    repeat (2) @(negedge CPUCL);
    check("idle after release BUSY", BUSY, 0);
    check("idle after release SRCRQ", SRCRQ, 0);

    for (int i = 0; i < 5; i++) run_row(tbl[i], i);

    // Reset asserted while the bytes of entry 5 are being copied.
    scen     = 6;
    cur_bank = 1'b0;
    cur_base = 16'hD800;
    max_wait = 0;
    spurious = 1'b0;
    fill_src(16'hD800, 0);
    check("sprb before midcopy reset", SPRB, 1);
    SRCBASE = 16'hD800;
    START   = 1'b1;
    @(negedge CPUCL);
    START = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      @(negedge CPUCL);
      #1;
      if (SATWE === 1'b1 && SATAD[7:0] === 8'h17) found = 1'b1;
    end
    check("reached entry5 RDB", found, 1);
    RESETn = 1'b0;
    #1;
    check("midcopy reset SPRB", SPRB, 0);
    check("midcopy reset BUSY", BUSY, 0);
    check("midcopy reset SATWE", SATWE, 0);
    check("midcopy reset SRCRQ", SRCRQ, 0);
    check("midcopy reset LIVE", LIVE, 0);
    repeat (2) @(negedge CPUCL);
    RESETn = 1'b1;
    repeat (3) @(negedge CPUCL);
    check("post reset BUSY", BUSY, 0);
    check("post reset SATWE", SATWE, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
